dmem_responder: RTL and testbench

Data-memory responder on the load/store side of the execute unit. It accepts one request at a time over a valid/ready handshake: read or write, with byte address, store data and byte mask. It services the request from an internal word array after a fixed latency and returns read data plus an error flag over a second valid/ready handshake. It replaces the combinational data memory behind the ALU address path once the core becomes multi-cycle.

---
 rtl/dmem_responder.sv | 189 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store over a valid/ready request
// handshake, services it from an internal word array after LATENCY cycles
// and returns read data plus an error flag over a response handshake.
//
// Optional feature macro: DMEM_MISALIGN_CHECK_EN (flags misaligned half/word
// accesses as errors; undefined = no alignment check).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req_valid/ready request handshake
//   req_wen         1 = store, 0 = load
//   req_addr        byte address
//   req_size        0 byte, 1 half, 2/3 word
//   req_wdata       right-justified store data
//   req_wmask       right-justified byte mask, bits [7:4] ignored
//   resp_valid/ready response handshake
//   resp_rdata      load word shifted right by 8*addr[1:0]; 0 on stores/errors
//   resp_err        out-of-range (or misaligned) access
module dmem_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [7:0]            req_wmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned SPAN_LOG2 = DEPTH_LOG2 + 2;
    localparam int unsigned CNT_W     = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            r_state, w_next_state;
    logic [CNT_W-1:0]      r_cnt, w_next_cnt;

    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [1:0]            r_size;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_wmask;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_wen;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [1:0]            w_size;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [3:0]            w_wmask;
    logic [ADDR_WIDTH-1:0] w_off;
    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_index;
    logic [1:0]            w_lane;
    logic [4:0]            w_shift;
    logic                  w_misalign;
    logic                  w_ok;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata_sh;
    logic [DATA_WIDTH-1:0] w_rdata_sh;

    assign w_accept = req_valid && req_ready;

    // With LATENCY == 1 the commit edge is the accept edge, so the commit
    // must see the live request instead of the not-yet-loaded latches.
    assign w_wen   = (r_state == S_IDLE) ? req_wen        : r_wen;
    assign w_addr  = (r_state == S_IDLE) ? req_addr       : r_addr;
    assign w_size  = (r_state == S_IDLE) ? req_size       : r_size;
    assign w_wdata = (r_state == S_IDLE) ? req_wdata      : r_wdata;
    assign w_wmask = (r_state == S_IDLE) ? req_wmask[3:0] : r_wmask;

    // Address decode against the array window.
    assign w_off      = w_addr - BASE_ADDR;
    assign w_in_range = (w_addr >= BASE_ADDR) &&
                        (w_off[ADDR_WIDTH-1:SPAN_LOG2] == '0);
    assign w_index    = w_off[SPAN_LOG2-1:2];
    assign w_lane     = w_addr[1:0];
    assign w_shift    = {w_lane, 3'b000};

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_misalign = ((w_size == 2'd1) && w_lane[0]) ||
                        (w_size[1] && (w_lane != 2'd0));
`else
    assign w_misalign = 1'b0;
    logic w_unused_size;
    assign w_unused_size = ^w_size;
`endif

    logic w_unused_bits;
    assign w_unused_bits = ^{req_wmask[7:4], w_off[1:0]};

    assign w_ok       = w_in_range && !w_misalign;
    assign w_be       = 4'(w_wmask << w_lane);
    assign w_wdata_sh = w_wdata << w_shift;
    assign w_rdata_sh = r_mem[w_index] >> w_shift;

    // Array access happens only on the edge entering RESP; reset vetoes it.
    assign w_commit = !rst && (r_state != S_RESP) && (w_next_state == S_RESP);

    // Next-state and latency counter.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_cnt   = CNT_W'(LATENCY - 1);
                    w_next_state = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_next_cnt   = '0;
                    w_next_state = S_RESP;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, handshake outputs and response payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            req_ready  <= (w_next_state == S_IDLE);
            resp_valid <= (w_next_state == S_RESP);
            if (w_commit) begin
                resp_err   <= !w_ok;
                resp_rdata <= (!w_wen && w_ok) ? w_rdata_sh : '0;
            end
        end
    end

    // Request latches; contents only matter while a request is in flight.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wen   <= req_wen;
            r_addr  <= req_addr;
            r_size  <= req_size;
            r_wdata <= req_wdata;
            r_wmask <= req_wmask[3:0];
        end
    end

    // Byte-lane store into the array.
    always_ff @(posedge clk) begin
        if (w_commit && w_wen && w_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_index][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY = 2).
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int errors = 0;
    int checks = 0;

    dmem_responder dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete transaction with resp_ready held high. lat counts cycles
    // from the accept cycle to the first cycle with resp_valid high.
    task automatic xact(input logic wen, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input logic [7:0] wmask, output logic [31:0] rd,
                        output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_size   = size;
        req_wdata  = wdata;
        req_wmask  = wmask;
        resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", resp_err); end
        rst = 1'b0;
    endtask

    task automatic test_word;
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h8000_0010, 2'd2, 32'hDEAD_BEEF, 8'h0F, rd, er, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_resp got=%b/%h exp=0/00000000", er, rd); end
        xact(1'b0, 32'h8000_0010, 2'd2, 32'h0, 8'h00, rd, er, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got=%0d exp=2", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_resp got=%b/%h exp=0/deadbeef", er, rd); end
    endtask

    task automatic test_byte_store;
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h8000_0012, 2'd0, 32'h0000_00AA, 8'h01, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL sb_err got=%b exp=0", er); end
        xact(1'b0, 32'h8000_0010, 2'd2, 32'h0, 8'h00, rd, er, lat);
        checks++; if (rd !== 32'hDEAA_BEEF) begin errors++; $display("FAIL sb_merge got=%h exp=deaabeef", rd); end
        // Word DEAABEEF shifted right by 16, zero-filled; low byte is the stored AA.
        xact(1'b0, 32'h8000_0012, 2'd0, 32'h0, 8'h00, rd, er, lat);
        checks++; if (rd !== 32'h0000_DEAA) begin errors++; $display("FAIL lb_shift got=%h exp=0000deaa", rd); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h8000_0000, 2'd2, 32'hCAFE_F00D, 8'h0F, rd, er, lat);
        xact(1'b0, 32'h7FFF_FFFC, 2'd2, 32'h0, 8'h00, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oor_low got=%b/%h exp=1/00000000", er, rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL oor_latency got=%0d exp=2", lat); end
        xact(1'b1, 32'h8000_4000, 2'd2, 32'h1234_5678, 8'h0F, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oor_high got=%b/%h exp=1/00000000", er, rd); end
        xact(1'b0, 32'h8000_0000, 2'd2, 32'h0, 8'h00, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL oor_word0 got=%b/%h exp=0/cafef00d", er, rd); end
        // Last word of the window is still in range.
        xact(1'b1, 32'h8000_3FFC, 2'd2, 32'h0BAD_C0DE, 8'h0F, rd, er, lat);
        xact(1'b0, 32'h8000_3FFC, 2'd2, 32'h0, 8'h00, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'h0BAD_C0DE) begin errors++; $display("FAIL last_word got=%b/%h exp=0/0badc0de", er, rd); end
    endtask

    task automatic test_backpressure;
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_addr   = 32'h8000_0010;
        req_size   = 2'd2;
        req_wdata  = 32'h0;
        req_wmask  = 8'h00;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got=%b exp=1", resp_valid); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAA_BEEF || resp_err !== 1'b0 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got v=%b d=%h e=%b rdy=%b exp v=1 d=deaabeef e=0 rdy=0",
                         i, resp_valid, resp_rdata, resp_err, req_ready);
            end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_complete got v=%b rdy=%b exp v=0 rdy=1", resp_valid, req_ready); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h8000_0020, 2'd2, 32'h55AA_55AA, 8'h0F, rd, er, lat);
        @(negedge clk);
        req_valid  = 1'b1;
        req_wen    = 1'b1;
        req_addr   = 32'h8000_0020;
        req_size   = 2'd2;
        req_wdata  = 32'h1111_1111;
        req_wmask  = 8'h0F;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_wait got rdy=%b v=%b exp rdy=0 v=0", req_ready, resp_valid); end
        // Reset lands on what would be the commit edge.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after got rdy=%b v=%b exp rdy=1 v=0", req_ready, resp_valid); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle cyc=%0d got v=%b rdy=%b exp v=0 rdy=1", i, resp_valid, req_ready); end
        end
        xact(1'b0, 32'h8000_0020, 2'd2, 32'h0, 8'h00, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'h55AA_55AA) begin errors++; $display("FAIL rstmid_word got=%b/%h exp=0/55aa55aa", er, rd); end
    endtask

    task automatic test_misalign;
        logic [31:0] rd; logic er; int lat;
`ifdef DMEM_MISALIGN_CHECK_EN
        xact(1'b1, 32'h8000_0002, 2'd2, 32'hFFFF_FFFF, 8'h0F, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL mis_sw got=%b/%h exp=1/00000000", er, rd); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL mis_latency got=%0d exp=2", lat); end
        xact(1'b0, 32'h8000_0000, 2'd2, 32'h0, 8'h00, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL mis_word0 got=%b/%h exp=0/cafef00d", er, rd); end
`else
        xact(1'b1, 32'h8000_0030, 2'd2, 32'h1122_3344, 8'h0F, rd, er, lat);
        // Half store at lane 3: only the low byte lands, in byte 3.
        xact(1'b1, 32'h8000_0033, 2'd1, 32'h0000_BEEF, 8'h03, rd, er, lat);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL mis_sh_err got=%b exp=0", er); end
        xact(1'b0, 32'h8000_0030, 2'd2, 32'h0, 8'h00, rd, er, lat);
        checks++; if (rd !== 32'hEF22_3344) begin errors++; $display("FAIL mis_sh_word got=%h exp=ef223344", rd); end
        xact(1'b0, 32'h8000_0033, 2'd1, 32'h0, 8'h00, rd, er, lat);
        checks++; if (er !== 1'b0 || rd !== 32'h0000_00EF) begin errors++; $display("FAIL mis_lh got=%b/%h exp=0/000000ef", er, rd); end
`endif
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = 32'h0;
        req_size   = 2'd0;
        req_wdata  = 32'h0;
        req_wmask  = 8'h00;
        resp_ready = 1'b1;
        test_reset();
        test_word();
        test_byte_store();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_misalign();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
